pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the Y86-64 pipelined core. It replaces the per-stage hand-written registers (F/D/E/M/W) with one block that has uniform stall and bubble semantics, a complete architectural bubble (NOP) state, and asynchronous reset into that state. It adds a valid flag, a sticky stall/bubble conflict flag, and saturating stall/bubble event counters for performance analysis. One instance sits between each pair of adjacent stages, driven by the pipeline control logic.

## Interface
Parameters:
- DATA_W, 64, width of each value field (valA/valB/valC…)
- NUM_VAL, 3, number of value fields carried; packed into one bus, field k at bits [k*DATA_W +: DATA_W]
- REG_W, 4, width of register-ID fields (dstE, dstM, srcA, srcB)
- CNT_W, 16, width of each event counter
- BUB_ICODE, 4'h1, icode inserted by bubble/reset (INOP)
- BUB_STAT, 4'h1, stat inserted by bubble/reset (SAOK)

Ports:
- clk  in  1  stage clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents
- bubble  in  1  load NOP state
- cnt_clr  in  1  synchronous clear of both counters and the conflict flag
- in_stat  in  4  incoming status
- in_icode, in_ifun  in  4 each  incoming instruction code/function
- in_val  in  NUM_VAL*DATA_W  incoming value fields
- in_dstE, in_dstM, in_srcA, in_srcB  in  REG_W each  incoming register IDs
- out_stat, out_icode, out_ifun, out_val, out_dstE, out_dstM, out_srcA, out_srcB  out  widths as inputs  registered copies
- out_valid  out  1  1 when contents came from a real load (not bubble/reset)
- conflict  out  1  sticky; set when stall and bubble are sampled high together
- stall_cnt, bubble_cnt  out  CNT_W each  saturating event counters

## Operation
- Bubble state: icode=BUB_ICODE, ifun=0, stat=BUB_STAT, all val fields=0, dstE=dstM=srcA=srcB={REG_W{1'b1}} (RNONE), out_valid=0.
- Reset (async assert, any time): all outputs go to bubble state immediately; conflict=0; both counters=0. Deassertion takes effect on the next rising clk edge.
- Per rising edge, priority order:
  1. bubble=1: load bubble state into every field (including ifun, stat, val, srcA/srcB; no field retains old data). bubble_cnt increments. If stall=1 too, conflict is set and stall_cnt does not increment (bubble wins).
  2. stall=1, bubble=0: all fields and out_valid hold. stall_cnt increments.
  3. Otherwise: all fields load from inputs; out_valid=1.
- Counters saturate at 2^CNT_W−1 and never wrap.
- cnt_clr=1: counters and conflict go to 0 at this edge. This overrides any increment or conflict set in the same cycle. The data path is unaffected and still follows the priority rules above.
- Payload is never interpreted; the block does not decode icode.

## Timing
- Latency 1 cycle input→output on a normal load; outputs are purely registered, with no combinational path from any input to any output.
- Bubble: NOP visible in the cycle after the edge where bubble was sampled.
- Stall of N cycles: outputs constant for N cycles; the first load after stall release captures the inputs present at that edge.
- Counter and conflict updates are visible the cycle after the sampled edge.
- rst is the only asynchronous input; stall, bubble and cnt_clr are sampled only at rising edges.

## Test plan
- Reset mid-stream: load icode=6, valA=64'h1234, then assert rst between edges → outputs immediately icode=1, stat=1, dst*=4'hF, val=0, out_valid=0, counters 0.
- Normal flow: 3 back-to-back loads (icode 2,3,6) → each appears 1 cycle later; out_valid=1; counters stay 0.
- Stall 4 cycles while inputs change: load icode=5/valC=8, stall 4 edges with new inputs → outputs hold 5/8; stall_cnt=4; the next edge loads the current inputs.
- Bubble over live data: ifun=3, stat=2, srcA=4, then bubble 1 edge → ifun=0, stat=1, srcA=4'hF, val=0, out_valid=0, bubble_cnt=1.
- Simultaneous stall+bubble: one edge → bubble state loaded, conflict=1 (sticky across later normal cycles), stall_cnt unchanged, bubble_cnt+1; cnt_clr on the same edge as a further stall+bubble → conflict=0, counters 0.
- Saturation with CNT_W=3: 10 consecutive stalls → stall_cnt reaches 7 and remains 7.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with uniform stall/bubble handling, a valid flag,
// a sticky stall+bubble conflict flag and saturating stall/bubble event counters.
module pipe_stage_reg #(
  parameter int          DATA_W    = 64,
  parameter int          NUM_VAL   = 3,
  parameter int          REG_W     = 4,
  parameter int          CNT_W     = 16,
  parameter logic [3:0]  BUB_ICODE = 4'h1,
  parameter logic [3:0]  BUB_STAT  = 4'h1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      bubble,
  input  logic                      cnt_clr,
  input  logic [3:0]                in_stat,
  input  logic [3:0]                in_icode,
  input  logic [3:0]                in_ifun,
  input  logic [NUM_VAL*DATA_W-1:0] in_val,
  input  logic [REG_W-1:0]          in_dstE,
  input  logic [REG_W-1:0]          in_dstM,
  input  logic [REG_W-1:0]          in_srcA,
  input  logic [REG_W-1:0]          in_srcB,
  output logic [3:0]                out_stat,
  output logic [3:0]                out_icode,
  output logic [3:0]                out_ifun,
  output logic [NUM_VAL*DATA_W-1:0] out_val,
  output logic [REG_W-1:0]          out_dstE,
  output logic [REG_W-1:0]          out_dstM,
  output logic [REG_W-1:0]          out_srcA,
  output logic [REG_W-1:0]          out_srcB,
  output logic                      out_valid,
  output logic                      conflict,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam logic [REG_W-1:0] RNONE   = {REG_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]                stat_q, stat_d;
  logic [3:0]                icode_q, icode_d;
  logic [3:0]                ifun_q, ifun_d;
  logic [NUM_VAL*DATA_W-1:0] val_q, val_d;
  logic [REG_W-1:0]          dste_q, dste_d;
  logic [REG_W-1:0]          dstm_q, dstm_d;
  logic [REG_W-1:0]          srca_q, srca_d;
  logic [REG_W-1:0]          srcb_q, srcb_d;
  logic                      valid_q, valid_d;
  logic                      conflict_q, conflict_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]          bubble_cnt_q, bubble_cnt_d;

  // Payload next-state: bubble beats stall, stall holds, otherwise load
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    val_d   = val_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    valid_d = valid_q;
    if (bubble) begin
      stat_d  = BUB_STAT;
      icode_d = BUB_ICODE;
      ifun_d  = 4'h0;
      val_d   = {(NUM_VAL*DATA_W){1'b0}};
      dste_d  = RNONE;
      dstm_d  = RNONE;
      srca_d  = RNONE;
      srcb_d  = RNONE;
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      stat_d  = in_stat;
      icode_d = in_icode;
      ifun_d  = in_ifun;
      val_d   = in_val;
      dste_d  = in_dstE;
      dstm_d  = in_dstM;
      srca_d  = in_srcA;
      srcb_d  = in_srcB;
      valid_d = 1'b1;
    end
  end

  // Event bookkeeping; a clear in the same cycle overrides any increment or set
  always_comb begin
    conflict_d   = conflict_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      conflict_d   = 1'b0;
      stall_cnt_d  = {CNT_W{1'b0}};
      bubble_cnt_d = {CNT_W{1'b0}};
    end else begin
      conflict_d = conflict_q | (stall & bubble);
      if (stall && !bubble && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (bubble && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  // State register; reset drops straight into the bubble state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q       <= BUB_STAT;
      icode_q      <= BUB_ICODE;
      ifun_q       <= 4'h0;
      val_q        <= {(NUM_VAL*DATA_W){1'b0}};
      dste_q       <= RNONE;
      dstm_q       <= RNONE;
      srca_q       <= RNONE;
      srcb_q       <= RNONE;
      valid_q      <= 1'b0;
      conflict_q   <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stat_q       <= stat_d;
      icode_q      <= icode_d;
      ifun_q       <= ifun_d;
      val_q        <= val_d;
      dste_q       <= dste_d;
      dstm_q       <= dstm_d;
      srca_q       <= srca_d;
      srcb_q       <= srcb_d;
      valid_q      <= valid_d;
      conflict_q   <= conflict_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_stat   = stat_q;
  assign out_icode  = icode_q;
  assign out_ifun   = ifun_q;
  assign out_val    = val_q;
  assign out_dstE   = dste_q;
  assign out_dstM   = dstm_q;
  assign out_srcA   = srca_q;
  assign out_srcB   = srcb_q;
  assign out_valid  = valid_q;
  assign conflict   = conflict_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CNT_W=3 so saturation is reachable quickly).
module tb_pipe_stage_reg;

  localparam int DW = 64;
  localparam int NV = 3;
  localparam int RW = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [NV*DW-1:0] val;
    logic [RW-1:0]    dste;
    logic [RW-1:0]    dstm;
    logic [RW-1:0]    srca;
    logic [RW-1:0]    srcb;
    logic             valid;
    logic             confl;
    logic [CW-1:0]    scnt;
    logic [CW-1:0]    bcnt;
  } out_t;

  logic clk = 1'b0;
  logic rst, stall, bubble, cnt_clr;
  logic [3:0] in_stat, in_icode, in_ifun;
  logic [NV*DW-1:0] in_val;
  logic [RW-1:0] in_dstE, in_dstM, in_srcA, in_srcB;
  logic [3:0] out_stat, out_icode, out_ifun;
  logic [NV*DW-1:0] out_val;
  logic [RW-1:0] out_dstE, out_dstM, out_srcA, out_srcB;
  logic out_valid, conflict;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  int tests = 0;
  int fails = 0;
  out_t sb[$];
  out_t m;
  out_t got;
  out_t exp_o;

  pipe_stage_reg #(.DATA_W(DW), .NUM_VAL(NV), .REG_W(RW), .CNT_W(CW),
                   .BUB_ICODE(4'h1), .BUB_STAT(4'h1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun), .in_val(in_val),
    .in_dstE(in_dstE), .in_dstM(in_dstM), .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun), .out_val(out_val),
    .out_dstE(out_dstE), .out_dstM(out_dstM), .out_srcA(out_srcA), .out_srcB(out_srcB),
    .out_valid(out_valid), .conflict(conflict), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t s;
    s.stat = out_stat;   s.icode = out_icode; s.ifun = out_ifun; s.val = out_val;
    s.dste = out_dstE;   s.dstm = out_dstM;   s.srca = out_srcA; s.srcb = out_srcB;
    s.valid = out_valid; s.confl = conflict;  s.scnt = stall_cnt; s.bcnt = bubble_cnt;
    return s;
  endfunction

  function automatic out_t nop_fields(input out_t o);
    out_t r = o;
    r.stat = 4'h1; r.icode = 4'h1; r.ifun = 4'h0; r.val = '0;
    r.dste = 4'hF; r.dstm = 4'hF; r.srca = 4'hF; r.srcb = 4'hF; r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == 3'd7) ? c : c + 3'd1;
  endfunction

  task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] st,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] ra);
    in_icode = ic; in_ifun = fn; in_stat = st;
    in_val = {vc, vb, va};
    in_dstE = ra + 4'd1; in_dstM = ra + 4'd2; in_srcA = ra; in_srcB = ra + 4'd3;
  endtask

  // Applies controls for one edge, predicts the result, queues it and lets the edge pass.
  task automatic step(input logic st, input logic bu, input logic clr);
    out_t n = m;
    stall = st; bubble = bu; cnt_clr = clr;
    if (bu) begin
      n = nop_fields(m);
      n.bcnt = sat_inc(m.bcnt);
      n.confl = m.confl | st;
    end else if (!st) begin
      n.stat = in_stat; n.icode = in_icode; n.ifun = in_ifun; n.val = in_val;
      n.dste = in_dstE; n.dstm = in_dstM; n.srca = in_srcA; n.srcb = in_srcB;
      n.valid = 1'b1;
    end else begin
      n.scnt = sat_inc(m.scnt);
    end
    if (clr) begin
      n.confl = 1'b0; n.scnt = '0; n.bcnt = '0;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; bubble = 1'b0; cnt_clr = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'h0);
    m = nop_fields('0);
    #1;
    got = sample(); tests++;
    if (got !== m) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", got, m);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_in(4'h6, 4'h0, 4'h1, 64'h1234, 64'h55, 64'h66, 4'h2);
    step(1'b0, 1'b0, 1'b0);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o) begin
      fails++; $display("FAIL rstmid_load got=%h exp=%h", got, exp_o);
    end
    step(1'b1, 1'b0, 1'b0);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o) begin
      fails++; $display("FAIL rstmid_stall got=%h exp=%h", got, exp_o);
    end
    #2 rst = 1'b1;
    #1;
    m = nop_fields('0);
    got = sample(); tests++;
    if (got !== m) begin
      fails++; $display("FAIL rstmid_async got=%h exp=%h", got, m);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [3:0] codes[3] = '{4'h2, 4'h3, 4'h6};
    for (int i = 0; i < 3; i++) begin
      set_in(codes[i], 4'(i), 4'h1, 64'(i * 17 + 3), 64'($urandom), 64'($urandom), 4'(i + 4));
      step(1'b0, 1'b0, 1'b0);
      got = sample(); exp_o = sb.pop_front(); tests++;
      if (got !== exp_o || got.icode !== codes[i] || got.valid !== 1'b1) begin
        fails++; $display("FAIL normal_load%0d got=%h exp=%h", i, got, exp_o);
      end
    end
  endtask

  task automatic test_stall();
    set_in(4'h5, 4'h0, 4'h1, 64'h1, 64'h2, 64'h8, 4'h1);
    step(1'b0, 1'b0, 1'b1);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o) begin
      fails++; $display("FAIL stall_first_load got=%h exp=%h", got, exp_o);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(4'(7 + i), 4'h2, 4'h3, 64'(100 + i), 64'(200 + i), 64'(300 + i), 4'(8 + i));
      step(1'b1, 1'b0, 1'b0);
      got = sample(); exp_o = sb.pop_front(); tests++;
      if (got !== exp_o || got.icode !== 4'h5 || got.val[191:128] !== 64'h8) begin
        fails++; $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp_o);
      end
    end
    tests++;
    if (stall_cnt !== 3'd4) begin
      fails++; $display("FAIL stall_count got=%0d exp=4", stall_cnt);
    end
    step(1'b0, 1'b0, 1'b0);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o || got.icode !== 4'hA || got.val[191:128] !== 64'd303) begin
      fails++; $display("FAIL stall_release got=%h exp=%h", got, exp_o);
    end
  endtask

  task automatic test_bubble();
    set_in(4'h6, 4'h3, 4'h2, 64'hAA, 64'hBB, 64'hCC, 4'h4);
    step(1'b0, 1'b0, 1'b1);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o) begin
      fails++; $display("FAIL bubble_pre got=%h exp=%h", got, exp_o);
    end
    step(1'b0, 1'b1, 1'b0);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o || got.ifun !== 4'h0 || got.stat !== 4'h1 || got.srca !== 4'hF ||
        got.val !== '0 || got.valid !== 1'b0 || got.bcnt !== 3'd1) begin
      fails++; $display("FAIL bubble_nop got=%h exp=%h", got, exp_o);
    end
  endtask

  task automatic test_conflict();
    set_in(4'h2, 4'h1, 4'h1, 64'h10, 64'h20, 64'h30, 4'h3);
    step(1'b1, 1'b1, 1'b0);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o || got.confl !== 1'b1 || got.scnt !== 3'd0 || got.bcnt !== 3'd2) begin
      fails++; $display("FAIL conflict_set got=%h exp=%h", got, exp_o);
    end
    for (int i = 0; i < 2; i++) begin
      set_in(4'(3 + i), 4'h0, 4'h1, 64'(i), 64'(i + 1), 64'(i + 2), 4'h6);
      step(1'b0, 1'b0, 1'b0);
      got = sample(); exp_o = sb.pop_front(); tests++;
      if (got !== exp_o || got.confl !== 1'b1) begin
        fails++; $display("FAIL conflict_sticky%0d got=%h exp=%h", i, got, exp_o);
      end
    end
    step(1'b1, 1'b1, 1'b1);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o || got.confl !== 1'b0 || got.scnt !== 3'd0 || got.bcnt !== 3'd0 ||
        got.valid !== 1'b0) begin
      fails++; $display("FAIL conflict_clr got=%h exp=%h", got, exp_o);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b0, 1'b1);
    got = sample(); exp_o = sb.pop_front(); tests++;
    if (got !== exp_o) begin
      fails++; $display("FAIL sat_clear got=%h exp=%h", got, exp_o);
    end
    for (int i = 0; i < 10; i++) begin
      in_icode = 4'(i);
      step(1'b1, 1'b0, 1'b0);
      got = sample(); exp_o = sb.pop_front(); tests++;
      if (got !== exp_o) begin
        fails++; $display("FAIL sat_stall%0d got=%h exp=%h", i, got, exp_o);
      end
    end
    tests++;
    if (stall_cnt !== 3'd7) begin
      fails++; $display("FAIL sat_final got=%0d exp=7", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_normal();
    test_stall();
    test_bubble();
    test_conflict();
    test_saturation();
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
